crypto_bus_arbiter: RTL and testbench

Round-robin arbiter and multiplexer for the shared 8-bit crypto data bus between the four interconnect agents: mem, sha, aes and ctrl. It grants the bus to one requester at a time and holds the grant for a whole packet, ending at the `last` beat. It routes the granted source's beats and `ready` onto the bus, and optionally reclaims the bus from a stalled owner via a watchdog. It sits upstream of the ack bus: one packet is granted here, then acknowledged on the ack bus.

---
 rtl/crypto_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_crypto_bus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_bus_arbiter.sv
// Round-robin arbiter and packet mux for the shared 8-bit crypto data bus (mem, sha, aes, ctrl).
// Optional stalled-owner watchdog is built when CRYPTO_ARB_WATCHDOG_EN is defined.
module crypto_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req_i,
   input  logic [31:0] src_data_i,
   input  logic [3:0]  src_valid_i,
   input  logic [3:0]  src_last_i,
   output logic [3:0]  src_ready_o,
   output logic [7:0]  bus_data_o,
   output logic        bus_valid_o,
   output logic        bus_last_o,
   input  logic        bus_ready_i,
   output logic [3:0]  gnt_o,
   output logic [1:0]  gnt_id_o,
   output logic        busy_o,
   output logic        timeout_o
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {StIdle, StXfer, StRelease} state_e;

   state_e     state_q;
   logic [3:0] gnt_q;
   logic [1:0] gnt_id_q;
   logic [1:0] ptr_q;
   logic       busy_q;

   logic [1:0] win_id;
   logic       win_any;
   logic [1:0] rr_idx;
   logic       hs;
   logic       withdraw;

   // Scan from the farthest offset down so the nearest requester after ptr wins.
   always_comb begin
      win_id  = ptr_q;
      win_any = 1'b0;
      rr_idx  = ptr_q;
      for (int i = 3; i >= 0; i--) begin
         rr_idx = ptr_q + 2'(i);
         if (req_i[rr_idx]) begin
            win_id  = rr_idx;
            win_any = 1'b1;
         end
      end
   end

   always_comb begin
      src_ready_o = 4'b0000;
      bus_data_o  = 8'h00;
      bus_valid_o = 1'b0;
      bus_last_o  = 1'b0;
      if (busy_q) begin
         bus_data_o            = src_data_i[{gnt_id_q, 3'b000} +: 8];
         bus_valid_o           = src_valid_i[gnt_id_q];
         bus_last_o            = src_last_i[gnt_id_q];
         src_ready_o[gnt_id_q] = bus_ready_i;
      end
   end

   assign hs       = bus_valid_o & bus_ready_i;
   assign withdraw = ~req_i[gnt_id_q] & ~src_valid_i[gnt_id_q];

`ifdef CRYPTO_ARB_WATCHDOG_EN
   logic [7:0] wdog_q;
   logic       timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         gnt_q     <= 4'b0000;
         gnt_id_q  <= 2'd0;
         ptr_q     <= 2'd0;
         busy_q    <= 1'b0;
         wdog_q    <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               wdog_q <= 8'd0;
               if (win_any) begin
                  state_q  <= StXfer;
                  gnt_q    <= 4'b0001 << win_id;
                  gnt_id_q <= win_id;
                  busy_q   <= 1'b1;
               end
            end
            StXfer: begin
               // A last-beat handshake or withdrawal wins over a coincident timeout.
               if ((hs && bus_last_o) || withdraw ||
                   (!hs && wdog_q == 8'(TIMEOUT_CYCLES - 1))) begin
                  state_q   <= StRelease;
                  gnt_q     <= 4'b0000;
                  gnt_id_q  <= 2'd0;
                  busy_q    <= 1'b0;
                  ptr_q     <= gnt_id_q + 2'd1;
                  wdog_q    <= 8'd0;
                  timeout_q <= !((hs && bus_last_o) || withdraw);
               end else if (hs) begin
                  wdog_q <= 8'd0;
               end else begin
                  wdog_q <= wdog_q + 8'd1;
               end
            end
            StRelease: begin
               state_q   <= StIdle;
               timeout_q <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign timeout_o = timeout_q;
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         gnt_q    <= 4'b0000;
         gnt_id_q <= 2'd0;
         ptr_q    <= 2'd0;
         busy_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (win_any) begin
                  state_q  <= StXfer;
                  gnt_q    <= 4'b0001 << win_id;
                  gnt_id_q <= win_id;
                  busy_q   <= 1'b1;
               end
            end
            StXfer: begin
               if ((hs && bus_last_o) || withdraw) begin
                  state_q  <= StRelease;
                  gnt_q    <= 4'b0000;
                  gnt_id_q <= 2'd0;
                  busy_q   <= 1'b0;
                  ptr_q    <= gnt_id_q + 2'd1;
               end
            end
            StRelease: state_q <= StIdle;
            default:   state_q <= StIdle;
         endcase
      end
   end

   assign timeout_o = 1'b0;
`endif

   assign gnt_o    = gnt_q;
   assign gnt_id_o = gnt_id_q;
   assign busy_o   = busy_q;

endmodule

// File: tb/tb_crypto_bus_arbiter.sv
// Bench for crypto_bus_arbiter: packet-level reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_crypto_bus_arbiter;

`ifdef CRYPTO_ARB_WATCHDOG_EN
   localparam int TMO = 4;
   localparam bit WD  = 1'b1;
`else
   localparam int TMO = 255;
   localparam bit WD  = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  valid;
   logic [3:0]  last;
   logic        bready;
   logic [3:0]  src_ready;
   logic [7:0]  bus_data;
   logic        bus_valid;
   logic        bus_last;
   logic [3:0]  gnt;
   logic [1:0]  gnt_id;
   logic        busy;
   logic        timeout;

   always #5 clk = ~clk;

   crypto_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req),
      .src_data_i  (data),
      .src_valid_i (valid),
      .src_last_i  (last),
      .src_ready_o (src_ready),
      .bus_data_o  (bus_data),
      .bus_valid_o (bus_valid),
      .bus_last_o  (bus_last),
      .bus_ready_i (bready),
      .gnt_o       (gnt),
      .gnt_id_o    (gnt_id),
      .busy_o      (busy),
      .timeout_o   (timeout)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the bus, cooldown cycles left, rotation pointer, stall count.
   int m_owner = -1;
   int m_gap   = 0;
   int m_ptr   = 0;
   int m_stall = 0;
   bit m_tmo   = 1'b0;
   bit started = 1'b0;

   task automatic model_release(input bit by_timeout);
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_gap   = 1;
      m_stall = 0;
      m_tmo   = by_timeout;
   endtask

   task automatic model_step();
      bit hs;
      int idx;
      m_tmo = 1'b0;
      if (rst) begin
         m_owner = -1;
         m_gap   = 0;
         m_ptr   = 0;
         m_stall = 0;
      end else if (m_owner >= 0) begin
         hs = valid[m_owner] && bready;
         if ((hs && last[m_owner]) || (!req[m_owner] && !valid[m_owner])) begin
            model_release(1'b0);
         end else if (hs) begin
            m_stall = 0;
         end else begin
            m_stall++;
            if (WD && m_stall >= TMO) model_release(1'b1);
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else begin
         for (int i = 0; i < 4; i++) begin
            idx = (m_ptr + i) % 4;
            if (m_owner < 0 && req[idx]) m_owner = idx;
         end
         m_stall = 0;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
      started = 1'b1;
   end

   // Compare process: every cycle, on the falling edge.
   initial forever begin
      @(negedge clk);
      if (started) begin
         if (m_owner >= 0) begin
            check("gnt", gnt, 32'(4'b0001 << m_owner));
            check("gnt_id", gnt_id, 32'(m_owner));
            check("busy", busy, 1);
            check("bus_data", bus_data, data[m_owner*8 +: 8]);
            check("bus_valid", bus_valid, valid[m_owner]);
            check("bus_last", bus_last, last[m_owner]);
            check("src_ready", src_ready, 32'(4'(bready) << m_owner));
         end else begin
            check("gnt", gnt, 0);
            check("gnt_id", gnt_id, 0);
            check("busy", busy, 0);
            check("bus_data", bus_data, 0);
            check("bus_valid", bus_valid, 0);
            check("bus_last", bus_last, 0);
            check("src_ready", src_ready, 0);
         end
         check("timeout", timeout, 32'(m_tmo));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_src(input int k, input logic [7:0] d, input logic v, input logic l);
      data[k*8 +: 8] = d;
      valid[k]       = v;
      last[k]        = l;
   endtask

   task automatic wait_busy(input string name);
      int n = 0;
      while (!busy && n < 12) begin
         tick();
         #1;
         n++;
      end
      if (!busy) check({name, "_grant_timeout"}, 0, 1);
   endtask

   logic [7:0] got[$];
   int         ids[$];
   int         cyc[$];
   logic [7:0] beats[4];
   bit         readies[4];

   initial begin
      int k, r, n, bad;
      rst = 1'b1; req = 4'hF; data = '0; valid = '0; last = '0; bready = 1'b1;

      // Reset held with all requesting
      tick(); tick(); #1;
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_src_ready", src_ready, 0);
      check("rst_bus_valid", bus_valid, 0);

      // Round-robin rotation, single-beat packets
      valid = 4'hF; last = 4'hF; data = 32'h44332211;
      rst = 1'b0;
      tick(); #1;
      check("first_gnt", gnt, 4'b0001);
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) begin
            tick(); #1;
         end
         if (busy) begin
            ids.push_back(int'(gnt_id));
            cyc.push_back(c);
         end
      end
      check("rr_count", ids.size(), 5);
      if (ids.size() == 5) begin
         check("rr_0", ids[0], 0);
         check("rr_1", ids[1], 1);
         check("rr_2", ids[2], 2);
         check("rr_3", ids[3], 3);
         check("rr_4", ids[4], 0);
         check("rr_spacing", cyc[4] - cyc[0], 12);
      end
      req = '0; valid = '0; last = '0;
      repeat (4) tick();

      // Multi-beat sha packet with ready toggling
      beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
      readies[0] = 1'b1; readies[1] = 1'b0; readies[2] = 1'b1; readies[3] = 1'b1;
      req = 4'b0010; set_src(1, 8'hA1, 1'b1, 1'b0);
      k = 0; r = 0; n = 0; bad = 0;
      while (k < 3 && n < 20) begin
         tick();
         if (busy && r < 4) begin
            bready = readies[r];
            r++;
         end
         set_src(1, beats[k], 1'b1, k == 2);
         #1;
         if ((src_ready & 4'b1101) != 0) bad++;
         if (busy && bus_valid && bready) begin
            got.push_back(bus_data);
            k++;
         end
         n++;
      end
      req = '0; valid = '0; last = '0; bready = 1'b1;
      tick(); #1;
      check("mb_drop_after_last", busy, 0);
      check("mb_other_ready", bad, 0);
      check("mb_beats", got.size(), 3);
      if (got.size() == 3) begin
         check("mb_a1", got[0], 8'hA1);
         check("mb_a2", got[1], 8'hA2);
         check("mb_a3", got[2], 8'hA3);
      end
      repeat (2) tick();

      // Withdrawal by aes, then ptr must favour ctrl over mem
      req = 4'b0100;
      wait_busy("wd_aes");
      check("wd_aes_id", gnt_id, 2);
      req = '0;
      tick(); #1;
      check("wd_release", busy, 0);
      req = 4'b1001;
      tick(); tick(); #1;
      check("wd_ptr3_winner", gnt_id, 3);
      req = '0;
      repeat (3) tick();

      // aes single beat leaves ptr at ctrl, then reset in the middle of a ctrl packet
      req = 4'b0100; set_src(2, 8'h5A, 1'b1, 1'b1);
      wait_busy("aes_single");
      req = '0; valid = '0; last = '0;
      repeat (3) tick();
      beats[0] = 8'hC1; beats[1] = 8'hC2; beats[2] = 8'hC3; beats[3] = 8'hC4;
      req = 4'b1000; set_src(3, 8'hC1, 1'b1, 1'b0);
      k = 0; n = 0;
      while (k < 2 && n < 20) begin
         tick();
         set_src(3, beats[k], 1'b1, k == 3);
         #1;
         if (busy && bus_valid && bready) k++;
         n++;
      end
      check("rst_mid_beats", k, 2);
      rst = 1'b1; req = 4'hF;
      tick(); #1;
      check("rst_mid_gnt", gnt, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_valid", bus_valid, 0);
      check("rst_mid_ready", src_ready, 0);
      rst = 1'b0; valid = '0; last = '0;
      tick(); #1;
      check("rst_mid_ptr_mem", gnt, 4'b0001);
      req = '0;
      repeat (3) tick();

`ifdef CRYPTO_ARB_WATCHDOG_EN
      // Stalled mem owner is reclaimed after TMO idle cycles, then sha wins
      req = 4'b0001;
      wait_busy("wdog_mem");
      check("wdog_mem_id", gnt_id, 0);
      req = 4'b0011;
      n = 0;
      while (!timeout && n < 10) begin
         tick(); #1;
         n++;
      end
      check("wdog_delay", n, 4);
      check("wdog_busy_off", busy, 0);
      tick(); #1;
      check("wdog_pulse_once", timeout, 0);
      req = 4'b0010;
      wait_busy("wdog_sha");
      check("wdog_next_sha", gnt_id, 1);
      req = '0;
      repeat (3) tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected $finish");
      $fatal(1);
   end

endmodule
